prog_clock_divider: RTL

//   Multi-channel, runtime-programmable clock divider and tick generator. Each channel

---
 rtl/prog_clock_divider.sv | 115 +++++++++++
 1 files changed

// File: rtl/prog_clock_divider.sv
// rtl/prog_clock_divider.sv - multi-channel programmable clock divider and tick generator
// Optional feature: define CLKDIV_SYNC_EN to add the sync_clr restart input.
// Each channel counts enabled clk edges, toggles clk_out every half cycles and
// pulses tick on each rising toggle. New divisors are staged in a one-deep
// pending slot per channel and only take effect at a half-period boundary.
module prog_clock_divider #(
  parameter int CW       = 32,
  parameter int NCH      = 2,
  parameter int DEF_HALF = 500000,
  localparam int CHW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] en,
  input  logic           ld_valid,
  output logic           ld_ready,
  input  logic [CHW-1:0] ld_ch,
  input  logic [CW-1:0]  ld_half,
  output logic [NCH-1:0] clk_out,
  output logic [NCH-1:0] tick
`ifdef CLKDIV_SYNC_EN
  ,
  input  logic           sync_clr
`endif
);

  logic [NCH-1:0][CW-1:0] cnt_q, cnt_d;
  logic [NCH-1:0][CW-1:0] half_q, half_d;
  logic [NCH-1:0][CW-1:0] pend_half_q, pend_half_d;
  logic [NCH-1:0]         pend_q, pend_d;
  logic [NCH-1:0]         clk_out_q, clk_out_d;
  logic [NCH-1:0]         tick_q, tick_d;
  logic                   ld_take;

  assign clk_out = clk_out_q;
  assign tick    = tick_q;
  assign ld_take = ld_valid & ld_ready;

  // Ready follows the addressed channel's pending slot; unknown channels always accept and drop.
  always_comb begin
    ld_ready = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      if (ld_ch == CHW'(i)) ld_ready = ~pend_q[i];
    end
  end

  // Per-channel next state: restart, count/toggle with boundary apply, idle apply, then load capture.
  always_comb begin
    cnt_d       = cnt_q;
    half_d      = half_q;
    pend_half_d = pend_half_q;
    pend_d      = pend_q;
    clk_out_d   = clk_out_q;
    tick_d      = '0;
    for (int i = 0; i < NCH; i++) begin
`ifdef CLKDIV_SYNC_EN
      if (sync_clr) begin
        cnt_d[i]     = '0;
        clk_out_d[i] = 1'b0;
        if (pend_q[i]) begin
          half_d[i] = pend_half_q[i];
          pend_d[i] = 1'b0;
        end
      end else
`endif
      if (en[i]) begin
        if (cnt_q[i] == half_q[i] - CW'(1)) begin
          cnt_d[i]     = '0;
          clk_out_d[i] = ~clk_out_q[i];
          tick_d[i]    = ~clk_out_q[i];
          if (pend_q[i]) begin
            half_d[i] = pend_half_q[i];
            pend_d[i] = 1'b0;
          end
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end else if (pend_q[i]) begin
        // A stopped channel has no boundary to wait for, so restart its count with the new value.
        cnt_d[i]  = '0;
        half_d[i] = pend_half_q[i];
        pend_d[i] = 1'b0;
      end
    end
    // Capture happens after apply so a load taken on a boundary waits for the next one.
    if (ld_take) begin
      for (int i = 0; i < NCH; i++) begin
        if (ld_ch == CHW'(i)) begin
          pend_d[i]      = 1'b1;
          pend_half_d[i] = (ld_half == '0) ? CW'(1) : ld_half;
        end
      end
    end
  end

  // State registers with asynchronous reset to the default divisor.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      pend_half_q <= '0;
      pend_q      <= '0;
      clk_out_q   <= '0;
      tick_q      <= '0;
      for (int i = 0; i < NCH; i++) half_q[i] <= CW'(DEF_HALF);
    end else begin
      cnt_q       <= cnt_d;
      half_q      <= half_d;
      pend_half_q <= pend_half_d;
      pend_q      <= pend_d;
      clk_out_q   <= clk_out_d;
      tick_q      <= tick_d;
    end
  end

endmodule
